// File: rtl/adam_clk_div_ctrl.sv
// Divisor/enable sequencer for adam_clk_div: gates the divider, drains, loads a new
// divisor, holds the divided domain in reset, then re-enables the divider.
module adam_clk_div_ctrl #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned DEFAULT_DIV  = 0,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned RST_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_div,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [WIDTH-1:0] div,
  output logic             div_en,
  output logic             sub_rst_n,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_CYCLES = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [WIDTH-1:0] DIV_RESET  = WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RESET
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] pending, pending_nx;
  logic             req_flag, req_flag_nx;
  logic [WIDTH-1:0] div_nx;
  logic             div_en_nx, sub_rst_n_nx, req_ready_nx, busy_nx, done_nx;

  // Reset lands in RESET so power-on runs the same release sequence as a request,
  // with req_flag low so no done pulse is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET;
      cnt       <= RST_LOAD;
      pending   <= DIV_RESET;
      req_flag  <= 1'b0;
      div       <= DIV_RESET;
      div_en    <= 1'b0;
      sub_rst_n <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pending   <= pending_nx;
      req_flag  <= req_flag_nx;
      div       <= div_nx;
      div_en    <= div_en_nx;
      sub_rst_n <= sub_rst_n_nx;
      req_ready <= req_ready_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pending_nx   = pending;
    req_flag_nx  = req_flag;
    div_nx       = div;
    div_en_nx    = div_en;
    sub_rst_n_nx = sub_rst_n;
    req_ready_nx = req_ready;
    busy_nx      = busy;
    done_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          pending_nx   = req_div;
          req_flag_nx  = 1'b1;
          div_en_nx    = 1'b0;
          req_ready_nx = 1'b0;
          busy_nx      = 1'b1;
          cnt_nx       = DRAIN_LOAD;
          state_nx     = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          div_nx       = pending;
          sub_rst_n_nx = 1'b0;
          cnt_nx       = RST_LOAD;
          state_nx     = RESET;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESET: begin
        if (cnt == '0) begin
          sub_rst_n_nx = 1'b1;
          div_en_nx    = 1'b1;
          done_nx      = req_flag;
          req_flag_nx  = 1'b0;
          busy_nx      = 1'b0;
          req_ready_nx = 1'b1;
          state_nx     = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        cnt_nx   = RST_LOAD;
        state_nx = RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_adam_clk_div_ctrl.sv
// Self-checking bench: two instances (D=2,R=1 and D=4,R=3) share stimulus and are
// compared every cycle against a timeline model keyed on cycles since accept/release.
module tb_adam_clk_div_ctrl;

  localparam int W = 4;
  localparam int D_P [2]   = '{2, 4};
  localparam int R_P [2]   = '{1, 3};
  localparam int DEF_P [2] = '{0, 6};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [W-1:0] req_div;
  logic [W-1:0] div_o [2];
  logic         en_o [2], sub_o [2], rdy_o [2], busy_o [2], done_o [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  adam_clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(0), .DRAIN_CYCLES(2), .RST_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_div(req_div), .req_valid(req_valid),
    .req_ready(rdy_o[0]), .div(div_o[0]), .div_en(en_o[0]), .sub_rst_n(sub_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  adam_clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(6), .DRAIN_CYCLES(4), .RST_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_div(req_div), .req_valid(req_valid),
    .req_ready(rdy_o[1]), .div(div_o[1]), .div_en(en_o[1]), .sub_rst_n(sub_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 release after reset, 2 request in flight; age counts edges
  // since the accept edge (or since release), which fixes every output directly.
  int           mode [2]   = '{1, 1};
  int           age [2]    = '{0, 0};
  logic [W-1:0] cur [2]    = '{4'd0, 4'd6};
  logic [W-1:0] nxt [2]    = '{4'd0, 4'd0};
  bit           done_e [2] = '{0, 0};
  int           acc_b      = 0;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mode[i] = 1; age[i] = 0; cur[i] = W'(DEF_P[i]); done_e[i] = 0;
      end else begin
        done_e[i] = 0;
        case (mode[i])
          0: if (req_valid) begin
            mode[i] = 2; age[i] = 0; nxt[i] = req_div;
            if (i == 1) acc_b++;
          end
          1: begin
            age[i]++;
            if (age[i] >= R_P[i]) mode[i] = 0;
          end
          default: begin
            age[i]++;
            if (age[i] == D_P[i]) cur[i] = nxt[i];
            if (age[i] == D_P[i] + R_P[i]) begin mode[i] = 0; done_e[i] = 1; end
          end
        endcase
      end
    end
  end

  logic         prev_en [2]  = '{0, 0};
  logic [W-1:0] prev_div [2] = '{4'd0, 4'd0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] e_div;
      logic e_en, e_sub, e_busy, e_rdy, e_done;
      e_div = cur[i];
      if (!rst_n || mode[i] == 1) begin
        e_en = 0; e_sub = 0; e_busy = 1; e_rdy = 0; e_done = 0;
      end else if (mode[i] == 2) begin
        e_en = 0; e_sub = (age[i] >= D_P[i]) ? 1'b0 : 1'b1; e_busy = 1; e_rdy = 0; e_done = 0;
      end else begin
        e_en = 1; e_sub = 1; e_busy = 0; e_rdy = 1; e_done = done_e[i];
      end
      checkOutput("div", i, 32'(div_o[i]), 32'(e_div));
      checkOutput("div_en", i, 32'(en_o[i]), 32'(e_en));
      checkOutput("sub_rst_n", i, 32'(sub_o[i]), 32'(e_sub));
      checkOutput("busy", i, 32'(busy_o[i]), 32'(e_busy));
      checkOutput("req_ready", i, 32'(rdy_o[i]), 32'(e_rdy));
      checkOutput("done", i, 32'(done_o[i]), 32'(e_done));
      if (en_o[i] === 1'b1) begin
        checkOutput("inv_en_implies_sub", i, 32'(sub_o[i]), 32'd1);
        if (prev_en[i] === 1'b1) checkOutput("inv_div_stable", i, 32'(div_o[i]), 32'(prev_div[i]));
      end
      prev_en[i]  = en_o[i];
      prev_div[i] = div_o[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d);
    req_valid = v;
    req_div   = d;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cycles;
    rst_n = 1'b1; req_valid = 1'b0; req_div = '0;
    #1 rst_n = 1'b0;

    $display("[TB] power-on");
    repeat (3) tick();
    checkOutput("por_div", 0, 32'(div_o[0]), 32'd0);
    checkOutput("por_div_en", 0, 32'(en_o[0]), 32'd0);
    checkOutput("por_sub_rst_n", 0, 32'(sub_o[0]), 32'd0);
    checkOutput("por_busy", 0, 32'(busy_o[0]), 32'd1);
    checkOutput("por_ready", 0, 32'(rdy_o[0]), 32'd0);
    checkOutput("por_div", 1, 32'(div_o[1]), 32'd6);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_div_en", 0, 32'(en_o[0]), 32'd1);
    checkOutput("rel_sub_rst_n", 0, 32'(sub_o[0]), 32'd1);
    checkOutput("rel_ready", 0, 32'(rdy_o[0]), 32'd1);
    checkOutput("rel_done", 0, 32'(done_o[0]), 32'd0);
    checkOutput("rel_div_en", 1, 32'(en_o[1]), 32'd0);
    repeat (3) tick();

    $display("[TB] basic change and request while busy");
    applyStimulus(1'b1, 4'd5);
    checkOutput("e0_div_en", 0, 32'(en_o[0]), 32'd0);
    checkOutput("e0_div", 0, 32'(div_o[0]), 32'd0);
    checkOutput("e0_busy", 0, 32'(busy_o[0]), 32'd1);
    applyStimulus(1'b1, 4'd7);
    checkOutput("e1_busy", 0, 32'(busy_o[0]), 32'd1);
    applyStimulus(1'b1, 4'd7);
    checkOutput("e2_div", 0, 32'(div_o[0]), 32'd5);
    checkOutput("e2_sub_rst_n", 0, 32'(sub_o[0]), 32'd0);
    applyStimulus(1'b0, 4'd7);
    checkOutput("e3_div_en", 0, 32'(en_o[0]), 32'd1);
    checkOutput("e3_done", 0, 32'(done_o[0]), 32'd1);
    checkOutput("e3_busy", 0, 32'(busy_o[0]), 32'd0);
    checkOutput("e3_div", 0, 32'(div_o[0]), 32'd5);
    applyStimulus(1'b1, 4'd3);
    checkOutput("e4_done", 0, 32'(done_o[0]), 32'd0);
    checkOutput("e4_div_en", 0, 32'(en_o[0]), 32'd0);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);
    checkOutput("e6_div", 0, 32'(div_o[0]), 32'd3);
    applyStimulus(1'b0, 4'd0);
    checkOutput("e7_done", 1, 32'(done_o[1]), 32'd1);
    checkOutput("e7_div", 1, 32'(div_o[1]), 32'd5);
    repeat (3) tick();

    $display("[TB] reset mid-sequence");
    applyStimulus(1'b1, 4'd9);
    applyStimulus(1'b0, 4'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_div", 0, 32'(div_o[0]), 32'd0);
    checkOutput("mid_div_en", 0, 32'(en_o[0]), 32'd0);
    checkOutput("mid_sub_rst_n", 0, 32'(sub_o[0]), 32'd0);
    checkOutput("mid_busy", 0, 32'(busy_o[0]), 32'd1);
    checkOutput("mid_div", 1, 32'(div_o[1]), 32'd6);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rel_div", 0, 32'(div_o[0]), 32'd0);
    checkOutput("mid_rel_done", 0, 32'(done_o[0]), 32'd0);
    repeat (3) tick();
    checkOutput("mid_rel_div", 1, 32'(div_o[1]), 32'd6);

    $display("[TB] same-value request, D=4 R=3");
    applyStimulus(1'b1, 4'd2);
    req_valid = 1'b0;
    repeat (8) tick();
    checkOutput("same_pre_div", 1, 32'(div_o[1]), 32'd2);
    applyStimulus(1'b1, 4'd2);
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      checkOutput("same_div_en", 1, 32'(en_o[1]), (k >= 7) ? 32'd1 : 32'd0);
      checkOutput("same_sub_rst_n", 1, 32'(sub_o[1]), (k >= 4 && k <= 6) ? 32'd0 : 32'd1);
      checkOutput("same_done", 1, 32'(done_o[1]), (k == 7) ? 32'd1 : 32'd0);
    end

    $display("[TB] random requests");
    cycles = 0;
    acc_b = 0;
    while (acc_b < 100 && cycles < 4000) begin
      if ($urandom_range(249) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      applyStimulus($urandom_range(2) != 0, W'($urandom_range(15)));
      cycles++;
    end
    checkOutput("random_request_count", 1, (acc_b >= 100) ? 32'd1 : 32'd0, 32'd1);
    req_valid = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
